thresh_ctrl: RTL and testbench

Adaptive threshold controller for the gray-to-binary stage of the edge-detection pipeline.
- Taps the same 8-bit gray pixel stream that feeds the binarizer.
- Accumulates the mean gray level of each frame, then adds an offset and clamps the result.
- Drives the binarizer's 8-bit threshold input.
- Threshold changes only in inter-frame gaps, so every frame is binarized with a single threshold.
- Manual mode drives a software-supplied value instead, also committed only between frames.

---
 rtl/thresh_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_thresh_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/thresh_ctrl.sv
// thresh_ctrl: adaptive threshold for the gray-to-binary stage.
// Accumulates the mean gray level of each frame, divides with a restoring
// divider, applies a signed offset and clamp, and commits the result (or a
// manual value) to the binarizer only between frames.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   mode       0 = manual (man_value), 1 = auto (frame mean)
//   man_value  manual threshold
//   din        gray pixel
//   din_vld    pixel valid
//   din_sop    first pixel of frame (qualified by din_vld)
//   din_eop    last pixel of frame (qualified by din_vld)
//   value      registered threshold to binarizer
//   value_upd  one-cycle pulse when value changes
//   busy       divider running
//   frame_err  one-cycle pulse on a framing violation
//
// Divider states:
//   state  | meaning
//   S_IDLE | no division in progress
//   S_DIV  | restoring division, one quotient bit per cycle
//   S_DONE | quotient ready; offset/clamp written to the pending slot
module thresh_ctrl #(
  parameter int                SUM_W     = 27,
  parameter int                CNT_W     = 19,
  parameter logic [7:0]        DEF_VALUE = 8'd128,
  parameter logic signed [8:0] OFFSET    = 9'sd0,
  parameter logic [7:0]        MIN_VALUE = 8'd16,
  parameter logic [7:0]        MAX_VALUE = 8'd240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic [7:0] man_value,
  input  logic [7:0] din,
  input  logic       din_vld,
  input  logic       din_sop,
  input  logic       din_eop,
  output logic [7:0] value,
  output logic       value_upd,
  output logic       busy,
  output logic       frame_err
);

  localparam int BW = $clog2(SUM_W);
  localparam logic signed [10:0] MIN_S = $signed({3'b000, MIN_VALUE});
  localparam logic signed [10:0] MAX_S = $signed({3'b000, MAX_VALUE});

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t state_q, state_d;

  logic             in_frame;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] fin_sum;
  logic [CNT_W-1:0] fin_cnt;
  logic             sop, eop, frame_end, err_d;

  logic [SUM_W-1:0] dvd;      // dividend, shifts out MSB-first and fills with quotient bits
  logic [CNT_W-1:0] dvs;
  logic [CNT_W-1:0] rem;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W:0]   rem_sh, diff;
  logic             q_bit;
  logic             div_step, done;

  logic [7:0]         sat;
  logic signed [10:0] adj;
  logic [7:0]         res;
  logic [7:0]         pend_auto;
  logic               pend_vld;

  logic       commit_ok, pend_clr;
  logic [7:0] value_d;

  // ---------------- accumulator ----------------
  assign sop       = din_vld & din_sop;
  assign eop       = din_vld & din_eop;
  assign frame_end = eop & (in_frame | sop);
  assign err_d     = (sop & in_frame) | (eop & ~in_frame & ~sop);
  assign fin_sum   = sop ? SUM_W'(din) : sum + SUM_W'(din);
  assign fin_cnt   = sop ? CNT_W'(1)   : cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame  <= 1'b0;
      sum       <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_d;
      if (sop || (in_frame && din_vld)) begin
        sum <= fin_sum;
        cnt <= fin_cnt;
      end
      if (sop)
        in_frame <= ~eop;
      else if (eop)
        in_frame <= 1'b0;
    end
  end

  // ---------------- divider FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    div_step = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: if (frame_end) state_d = S_DIV;
      S_DIV: begin
        busy = 1'b1;
        if (!frame_end) begin
          div_step = 1'b1;
          if (bit_cnt == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // the finished quotient is still written even if a new frame ends now
        done    = 1'b1;
        state_d = frame_end ? S_DIV : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Remainder is always < divisor, so the shifted value fits CNT_W+1 bits and
  // the sign of the trial subtraction decides the quotient bit.
  assign rem_sh = {rem, dvd[SUM_W-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign q_bit  = ~diff[CNT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      bit_cnt <= '0;
    end else if (frame_end) begin
      dvd     <= fin_sum;
      dvs     <= fin_cnt;
      rem     <= '0;
      bit_cnt <= BW'(SUM_W - 1);
    end else if (div_step) begin
      dvd     <= {dvd[SUM_W-2:0], q_bit};
      rem     <= q_bit ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
      bit_cnt <= bit_cnt - BW'(1);
    end
  end

  // ---------------- saturate / offset / clamp ----------------
  always_comb begin
    sat = (|dvd[SUM_W-1:8]) ? 8'hFF : dvd[7:0];
    adj = $signed({3'b000, sat}) + $signed({{2{OFFSET[8]}}, OFFSET});
    if (adj < MIN_S)      res = MIN_VALUE;
    else if (adj > MAX_S) res = MAX_VALUE;
    else                  res = adj[7:0];
  end

  // ---------------- commit ----------------
  assign commit_ok = ~in_frame & ~sop;

  always_comb begin
    value_d  = value;
    pend_clr = 1'b0;
    if (commit_ok) begin
      if (mode) begin
        if (pend_vld) begin
          value_d  = pend_auto;
          pend_clr = 1'b1;
        end
      end else begin
        value_d = man_value;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_auto <= '0;
      pend_vld  <= 1'b0;
      value     <= DEF_VALUE;
      value_upd <= 1'b0;
    end else begin
      // a fresh result takes priority over clearing the slot
      if (done) begin
        pend_auto <= res;
        pend_vld  <= 1'b1;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end
      value     <= value_d;
      value_upd <= (value_d != value);
    end
  end

endmodule

// File: tb/tb_thresh_ctrl.sv
module tb_thresh_ctrl;
  localparam int SUM_W = 27;
  localparam int CNT_W = 19;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b1;
  logic [7:0] man_value = 8'd0;
  logic [7:0] din = 8'd0;
  logic       din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;

  logic [7:0] value0, value1;
  logic       upd0, upd1, busy0, busy1, err0, err1;

  always #5 clk = ~clk;

  thresh_ctrl #(.SUM_W(SUM_W), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .man_value(man_value),
    .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
    .value(value0), .value_upd(upd0), .busy(busy0), .frame_err(err0));

  thresh_ctrl #(.SUM_W(SUM_W), .CNT_W(CNT_W), .OFFSET(-9'sd10)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .man_value(man_value),
    .din(din), .din_vld(din_vld), .din_sop(din_sop), .din_eop(din_eop),
    .value(value1), .value_upd(upd1), .busy(busy1), .frame_err(err1));

  int vectors = 0;
  int errors  = 0;
  int n_upd = 0, n_err = 0, n_busy = 0;

  // ---------------- behavioural model ----------------
  function automatic int thresh_of(input int s, input int c, input int off);
    int q;
    q = s / c;
    if (q > 255) q = 255;
    q = q + off;
    if (q < 16)  q = 16;
    if (q > 240) q = 240;
    return q;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // a frame result becomes pending SUM_W+1 edges after its eop; a newer
  // frame end before that replaces it
  logic m_in_frame = 0, m_job_act = 0, m_pend_vld = 0, m_busy = 0, m_err = 0;
  logic m_upd0 = 0, m_upd1 = 0;
  int   m_sum = 0, m_cnt = 0, m_job_t = 0, m_job_sum = 0, m_job_cnt = 1;
  int   m_pend0 = 0, m_pend1 = 0, m_val0 = 128, m_val1 = 128;

  logic c_sop, c_eop, c_end, c_err, c_ok, c_done;
  int   f_sum, f_cnt, nv0, nv1;

  always_comb begin
    c_sop  = din_vld & din_sop;
    c_eop  = din_vld & din_eop;
    c_end  = c_eop & (m_in_frame | c_sop);
    c_err  = (c_sop & m_in_frame) | (c_eop & !m_in_frame & !c_sop);
    c_ok   = !m_in_frame & !c_sop;
    c_done = m_job_act && (cyc == m_job_t);
    f_sum  = c_sop ? int'(din) : m_sum + int'(din);
    f_cnt  = c_sop ? 1 : m_cnt + 1;
    nv0 = m_val0;
    nv1 = m_val1;
    if (c_ok) begin
      if (mode) begin
        if (m_pend_vld) begin
          nv0 = m_pend0;
          nv1 = m_pend1;
        end
      end else begin
        nv0 = int'(man_value);
        nv1 = int'(man_value);
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_frame <= 0; m_job_act <= 0; m_pend_vld <= 0; m_busy <= 0; m_err <= 0;
      m_upd0 <= 0; m_upd1 <= 0; m_sum <= 0; m_cnt <= 0;
      m_val0 <= 128; m_val1 <= 128;
    end else begin
      m_err <= c_err;
      if (c_sop || (m_in_frame && din_vld)) begin
        m_sum <= f_sum;
        m_cnt <= f_cnt;
      end
      if (c_sop)      m_in_frame <= !c_eop;
      else if (c_eop) m_in_frame <= 0;
      if (c_end) begin
        m_job_act <= 1;
        m_job_t   <= cyc + SUM_W + 1;
        m_job_sum <= f_sum;
        m_job_cnt <= f_cnt;
        m_busy    <= 1;
      end else begin
        if (c_done) m_job_act <= 0;
        m_busy <= m_job_act && (cyc + 1 < m_job_t);
      end
      if (c_done) begin
        m_pend_vld <= 1;
        m_pend0    <= thresh_of(m_job_sum, m_job_cnt, 0);
        m_pend1    <= thresh_of(m_job_sum, m_job_cnt, -10);
      end else if (c_ok && mode && m_pend_vld) begin
        m_pend_vld <= 0;
      end
      m_val0 <= nv0;
      m_val1 <= nv1;
      m_upd0 <= (nv0 != m_val0);
      m_upd1 <= (nv1 != m_val1);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (upd0)  n_upd++;
    if (err0)  n_err++;
    if (busy0) n_busy++;
    vectors++;
    if (value0 !== 8'(m_val0) || value1 !== 8'(m_val1) || upd0 !== m_upd0 ||
        upd1 !== m_upd1 || busy0 !== m_busy || busy1 !== m_busy ||
        err0 !== m_err || err1 !== m_err) begin
      errors++;
      $display("FAIL cycle %0d outputs: got v0=%0d v1=%0d upd=%b%b busy=%b%b err=%b%b want v0=%0d v1=%0d upd=%b%b busy=%b err=%b",
               cyc, value0, value1, upd0, upd1, busy0, busy1, err0, err1,
               m_val0, m_val1, m_upd0, m_upd1, m_busy, m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic e);
    @(posedge clk); #2;
    din_vld = v; din = d; din_sop = s; din_eop = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic frame_const(input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) drive(1'b1, d, i == 0, i == n - 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset value", int'(value0), 128);
    check("reset busy", int'(busy0), 0);

    // mean of 10,20,30,40 with exact latency
    n_busy = 0;
    drive(1, 10, 1, 0); drive(1, 20, 0, 0); drive(1, 30, 0, 0); drive(1, 40, 0, 1);
    idle(SUM_W + 2);
    @(negedge clk);
    check("mean before latency value", int'(value0), 128);
    check("mean before latency upd", int'(upd0), 0);
    idle(1);
    @(negedge clk);
    check("mean latency upd", int'(upd0), 1);
    check("mean value", int'(value0), 25);
    check("mean value offset", int'(value1), 16);
    check("busy cycles", n_busy, SUM_W);

    // clamps
    drive(1, 0, 1, 0); drive(1, 4, 0, 1);
    idle(SUM_W + 4);
    check("clamp low", int'(value0), 16);
    frame_const(4, 255);
    idle(SUM_W + 4);
    check("clamp high", int'(value0), 240);
    check("clamp high offset", int'(value1), 240);
    frame_const(4, 100);
    idle(SUM_W + 4);
    check("all 100", int'(value0), 100);
    check("all 100 offset -10", int'(value1), 90);

    // back-to-back frames, first division aborted
    n_upd = 0;
    drive(1, 40, 1, 0); drive(1, 50, 0, 0); drive(1, 60, 0, 1);
    idle(1);
    drive(1, 70, 1, 0); drive(1, 80, 0, 0); drive(1, 90, 0, 1);
    idle(SUM_W + 4);
    check("back-to-back value", int'(value0), 80);
    check("back-to-back updates", n_upd, 1);

    // result ready during next frame is held until after its eop
    drive(1, 200, 1, 0); drive(1, 200, 0, 1);
    idle(5);
    frame_const(SUM_W + 5, 10);
    idle(1);
    check("hold at eop", int'(value0), 80);
    idle(1);
    check("hold released value", int'(value0), 200);
    check("hold released upd", int'(upd0), 1);
    idle(SUM_W + 4);
    check("long frame value", int'(value0), 16);

    // second sop mid-frame
    n_err = 0;
    drive(1, 200, 1, 0); drive(1, 200, 0, 0);
    drive(1, 30, 1, 0); drive(1, 50, 0, 0); drive(1, 70, 0, 1);
    idle(SUM_W + 4);
    check("restart err", n_err, 1);
    check("restart mean", int'(value0), 50);

    // orphan eop
    n_err = 0; n_upd = 0;
    drive(1, 99, 0, 1);
    idle(SUM_W + 4);
    check("orphan err", n_err, 1);
    check("orphan no update", n_upd, 0);

    // manual value changed mid-frame
    drive(1, 1, 1, 0); drive(1, 2, 0, 0);
    mode = 1'b0; man_value = 8'd77;
    drive(1, 3, 0, 0); drive(1, 5, 0, 1);
    idle(1);
    check("manual held at eop", int'(value0), 50);
    idle(1);
    check("manual applied", int'(value0), 77);
    check("manual applied offset dut", int'(value1), 77);
    idle(SUM_W + 4);
    check("manual ignores auto", int'(value0), 77);
    mode = 1'b1;
    idle(2);
    check("auto pending commit", int'(value0), 16);

    // single-pixel frame
    frame_const(1, 150);
    idle(SUM_W + 4);
    check("one pixel frame", int'(value0), 150);

    // reset during division
    drive(1, 10, 1, 0); drive(1, 20, 0, 1);
    idle(5);
    rst = 1'b1;
    #1;
    check("reset mid value", int'(value0), 128);
    check("reset mid busy", int'(busy0), 0);
    idle(2);
    rst = 1'b0;
    n_upd = 0;
    idle(SUM_W + 6);
    check("after reset no update", n_upd, 0);
    check("after reset value", int'(value0), 128);
    frame_const(2, 60);
    idle(SUM_W + 4);
    check("after reset frame", int'(value0), 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
